// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle MIPS datapath.
// Contents: opcode field constants, the NOP encoding, the default reset PC,
// the fetch-stage state encoding and a sign-extension helper.
package mips_pkg;

  // Primary opcode field values (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Fetch-stage state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_VALID = 2'd2;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/pc_next.sv
// Next-PC selection for the instruction that is retiring.
// Ports:
//   pc_plus4 - address of the retiring instruction plus 4
//   instr    - low 26 bits of the retiring instruction (jump index / branch imm)
//   branch   - decoded beq
//   zero     - ALU equality result
//   jump     - decoded j (takes priority over branch)
//   next_pc  - address of the next instruction to fetch
module pc_next
  import mips_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [25:0] instr,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  output logic [31:0] next_pc
);

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      // Pseudo-direct: keep the region of the delay-slot address
      next_pc = {pc_plus4[31:28], instr, 2'b00};
    end else if (branch && zero) begin
      next_pc = pc_plus4 + (sext16(instr[15:0]) << 2);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the PC, requests one instruction at a time
// from instruction memory over a req/ready handshake, presents it to decode
// and advances the PC when decode lets it retire.
// Ports:
//   clk, rst               - clock, asynchronous active-high reset
//   imem_req, imem_addr    - fetch request and address (address == pc)
//   imem_ready, imem_rdata - memory response, sampled only while fetching
//   stall                  - held instruction cannot retire this cycle
//   branch, zero, jump     - next-PC controls for the held instruction
//   instr, opcode          - held instruction and its opcode field
//   instr_valid            - instr is valid and awaiting retirement
//   pc, pc_plus4           - current PC and PC + 4
//   retire_cnt             - number of retired instructions (wraps)
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] retire_cnt
);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] next_pc;

  assign pc_plus4 = pc_q + 32'd4;

  pc_next u_pc_next (
    .pc_plus4 (pc_plus4),
    .instr    (instr_q[25:0]),
    .branch   (branch),
    .zero     (zero),
    .jump     (jump),
    .next_pc  (next_pc)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = ST_VALID;
        end
      end
      ST_VALID: begin
        if (!stall) begin
          pc_d    = next_pc;
          cnt_d   = cnt_q + 32'd1;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake outputs decode straight from state: no input-to-output path
  assign imem_req    = (state_q == ST_FETCH);
  assign instr_valid = (state_q == ST_VALID);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign retire_cnt  = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios followed by random
// traffic, all compared against a transaction-level model of the fetch stage.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall, branch, zero, jump;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic [31:0] pc, pc_plus4, retire_cnt;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .branch      (branch),
    .zero        (zero),
    .jump        (jump),
    .instr       (instr),
    .opcode      (opcode),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .retire_cnt  (retire_cnt)
  );

  int checks   = 0;
  int failures = 0;

  // Model: has the stage left reset idle, is an instruction held, and the
  // architectural values it exposes.
  bit          m_started;
  bit          m_have;
  logic [31:0] m_pc, m_instr, m_cnt;

  function automatic logic [31:0] ref_next(input logic [31:0] cur_pc, input logic [31:0] word,
                                           input logic br, input logic z, input logic j);
    logic [31:0] seq;
    logic [31:0] idx;
    int          off;
    seq = cur_pc + 32'd4;
    if (j) begin
      idx = {6'b0, word[25:0]};
      return (seq & 32'hF000_0000) | (idx * 32'd4);
    end
    if (br && z) begin
      off = int'($signed(word[15:0]));
      return seq + 32'(off * 4);
    end
    return seq;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic model_reset();
    m_started = 1'b0;
    m_have    = 1'b0;
    m_pc      = 32'h0000_0000;
    m_instr   = 32'h0000_0000;
    m_cnt     = 32'd0;
  endtask

  task automatic check_all();
    chk("imem_req",    32'(imem_req),    32'(m_started && !m_have));
    chk("imem_addr",   imem_addr,        m_pc);
    chk("instr_valid", 32'(instr_valid), 32'(m_have));
    chk("instr",       instr,            m_instr);
    chk("opcode",      32'(opcode),      m_instr >> 26);
    chk("pc",          pc,               m_pc);
    chk("pc_plus4",    pc_plus4,         m_pc + 32'd4);
    chk("retire_cnt",  retire_cnt,       m_cnt);
  endtask

  // One clock: drive inputs, advance the model, sample 1 time unit after the edge
  task automatic step(input logic rdy, input logic [31:0] rd, input logic st,
                      input logic br, input logic z, input logic j);
    imem_ready = rdy;
    imem_rdata = rd;
    stall      = st;
    branch     = br;
    zero       = z;
    jump       = j;
    @(posedge clk);
    #1;
    if (!m_started) begin
      m_started = 1'b1;
    end else if (!m_have) begin
      if (rdy) begin
        m_instr = rd;
        m_have  = 1'b1;
      end
    end else if (!st) begin
      m_pc    = ref_next(m_pc, m_instr, br, z, j);
      m_cnt   = m_cnt + 32'd1;
      m_have  = 1'b0;
    end
    check_all();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] w;
    rst        = 1'b1;
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    stall      = 1'b0;
    branch     = 1'b0;
    zero       = 1'b0;
    jump       = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("reset_pc_plus4", pc_plus4, 32'h0000_0004);
    rst = 1'b0;

    // Zero-wait fetch of addi at 0
    step(1'b1, 32'h2008_0005, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("c2_req", 32'(imem_req), 32'd1);
    chk("c2_addr", imem_addr, 32'h0);
    step(1'b1, 32'h2008_0005, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("c3_valid", 32'(instr_valid), 32'd1);
    chk("c3_opcode", 32'(opcode), 32'h08);
    step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("c4_pc", pc, 32'h4);

    // Memory not ready for 5 cycles, then jump to 0x40
    repeat (5) begin
      step(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, 1'b1);
      chk("wait_addr", imem_addr, 32'h4);
    end
    step(1'b1, 32'h0800_0010, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wait_capture", instr, 32'h0800_0010);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("jump_40", pc, 32'h40);

    // Backward taken branch, then not-taken
    step(1'b1, 32'h1000_FFFE, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("beq_taken", pc, 32'h3C);
    step(1'b1, 32'h0800_0010, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h1000_FFFE, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("beq_not_taken", pc, 32'h44);

    // Stall for three cycles; controls must be ignored while stalled
    step(1'b1, 32'h0000_0020, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) begin
      step(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b1);
      chk("stall_pc", pc, 32'h44);
      chk("stall_instr", instr, 32'h20);
      chk("stall_cnt", retire_cnt, 32'd5);
    end
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("stall_retire_pc", pc, 32'h48);
    chk("stall_retire_cnt", retire_cnt, 32'd6);

    // Jump to 0x80, reset while holding a valid instruction
    step(1'b1, 32'h0800_0020, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("jump_80", pc, 32'h80);
    step(1'b1, 32'h8C00_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse_reset();
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_cnt", retire_cnt, 32'd0);

    // Branch back from 0 to 0xFFFF_FFFC, then sequential wrap to 0
    step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h1000_FFFE, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("pc_top", pc, 32'hFFFF_FFFC);
    step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pc_wrap", pc, 32'h0);

    // Reach 0x1000_0000, then jump+branch together: jump wins
    step(1'b1, 32'h0BFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("jump_region_end", pc, 32'h0FFF_FFFC);
    step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pc_region", pc, 32'h1000_0000);
    step(1'b1, 32'h0800_0010, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("jump_priority", pc, 32'h1000_0040);

    // Random traffic with occasional asynchronous resets
    for (int i = 0; i < 600; i++) begin
      r = $urandom;
      case ($urandom_range(0, 3))
        0:       w = {6'h02, r[25:0]};
        1:       w = {6'h04, r[25:0]};
        default: w = r;
      endcase
      if ($urandom_range(0, 99) == 0) begin
        pulse_reset();
      end else begin
        step(($urandom_range(0, 3) != 0), w, ($urandom_range(0, 2) == 0),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
